// File: rtl/bcd_cascade_disp.sv
// Synchronises an async ripple BCD count, extends it to NDIG digits by counting
// 9->0 wraps, and scans the result onto a multiplexed 7-segment display.
module bcd_cascade_disp #(
  parameter int NDIG     = 3,
  parameter int SYNC_STG = 2,
  parameter int SCAN_DIV = 4,
  parameter int BLANK    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          cnt_in,
  input  logic                en,
  input  logic                clr,
  output logic [4*NDIG-1:0]   bcd,
  output logic                ovf,
  output logic                err,
  output logic [6:0]          seg,
  output logic [NDIG-1:0]     an
);

  localparam int IW  = $clog2(NDIG);
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SYNC_STG-1:0][3:0] sync_q;
  logic [3:0]               h_q, u_q, u_d, s;
  logic [NDIG-1:1][3:0]     up_q, up_d;
  logic                     ovf_q, ovf_d, err_q, inv_q;
  logic [SCW-1:0]           sc_q;
  logic [IW-1:0]            idx_q;
  logic [6:0]               seg_q, seg_d;
  logic [NDIG-1:0]          an_q;
  logic                     stable, invalid, accept, carry, run_c, nz, blank;
  logic [3:0]               cur;
  logic [4*NDIG-1:0]        all_dig;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h00;
    endcase
  endfunction

  // A sample is trusted only once it has matched the previous cycle's sample,
  // which rejects the transient codes a ripple counter shows while settling.
  assign s       = sync_q[SYNC_STG-1];
  assign stable  = (s == h_q);
  assign invalid = stable && (s > 4'd9);
  assign accept  = stable && (s <= 4'd9) && (s != u_q);
  assign carry   = accept && (u_q == 4'd9) && (s == 4'd0) && en;
  assign u_d     = accept ? s : u_q;

  always_comb begin
    up_d  = up_q;
    run_c = carry;
    for (int i = 1; i < NDIG; i++) begin
      if (run_c) begin
        if (up_q[i] == 4'd9) begin
          up_d[i] = 4'd0;
        end else begin
          up_d[i] = up_q[i] + 4'd1;
          run_c   = 1'b0;
        end
      end
    end
    ovf_d = run_c;
    if (clr) begin
      up_d  = '0;
      ovf_d = 1'b0;
    end
  end

  assign all_dig = {up_q, u_q};

  // Leading-zero blanking: digit idx is dark when it and every higher digit are zero.
  always_comb begin
    cur = all_dig[{idx_q, 2'b00} +: 4];
    nz  = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= int'(idx_q) && all_dig[4*i +: 4] != 4'd0) nz = 1'b1;
    end
    blank = (BLANK != 0) && (idx_q != '0) && !nz;
    seg_d = blank ? 7'h00 : dec(cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      h_q    <= '0;
      u_q    <= '0;
      up_q   <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      inv_q  <= 1'b0;
      sc_q   <= '0;
      idx_q  <= '0;
      seg_q  <= 7'h00;
      an_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], cnt_in};
      h_q    <= s;
      u_q    <= u_d;
      up_q   <= up_d;
      ovf_q  <= ovf_d;
      inv_q  <= invalid;
      err_q  <= invalid && !inv_q;
      if (sc_q == SCW'(SCAN_DIV-1)) begin
        sc_q  <= '0;
        idx_q <= (idx_q == IW'(NDIG-1)) ? '0 : idx_q + IW'(1);
      end else begin
        sc_q <= sc_q + SCW'(1);
      end
      an_q   <= NDIG'(1) << idx_q;
      seg_q  <= seg_d;
    end
  end

  assign bcd = all_dig;
  assign ovf = ovf_q;
  assign err = err_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_cascade_disp.sv
// Scoreboard bench for bcd_cascade_disp: an integer count model predicts every
// accepted-count change and error pulse; a negedge monitor consumes them.
module tb_bcd_cascade_disp;
  localparam int NDIG = 3, SYNC_STG = 2, SCAN_DIV = 4, BLANK = 1;
  localparam int UMOD = 10 ** (NDIG - 1);

  logic clk = 1'b0;
  logic rst, en, clr;
  logic [3:0] cnt_in;
  logic [4*NDIG-1:0] bcd;
  logic ovf, err;
  logic [6:0] seg;
  logic [NDIG-1:0] an;

  typedef struct {bit is_err; int val; bit ovf;} ev_t;
  ev_t sb[$];
  ev_t mon_e;

  int total = 0, bad = 0;
  int m_units = 0, m_upper = 0;
  bit mon_en = 1'b0, last_inv = 1'b0, last_g = 1'b0;
  logic [4*NDIG-1:0] prev_bcd;
  bit [6:0] glyph [10];

  always #5 clk = ~clk;

  bcd_cascade_disp #(.NDIG(NDIG), .SYNC_STG(SYNC_STG), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .en(en), .clr(clr),
    .bcd(bcd), .ovf(ovf), .err(err), .seg(seg), .an(an));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < NDIG; k++) begin
      r[4*k +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal count = upper*10 + units; a 9->0 units step with en bumps upper.
  task automatic model_apply(input int v, input bit e);
    ev_t ev;
    ev.ovf = 1'b0;
    if (v > 9) begin
      ev.is_err = 1'b1;
      ev.val    = m_upper * 10 + m_units;
      sb.push_back(ev);
    end else if (v != m_units) begin
      if (m_units == 9 && v == 0 && e) begin
        m_upper = (m_upper + 1) % UMOD;
        ev.ovf  = (m_upper == 0);
      end
      m_units   = v;
      ev.is_err = 1'b0;
      ev.val    = m_upper * 10 + m_units;
      sb.push_back(ev);
    end
  endtask

  task automatic hold(input int v, input int n, input bit e);
    model_apply(v, e);
    en     = e;
    cnt_in = 4'(v);
    repeat (n) tick();
  endtask

  task automatic glitch(input int v);
    cnt_in = 4'(v);
    tick();
  endtask

  task automatic goto_cnt(input int target);
    while ((m_upper * 10 + m_units) != target) hold((m_units + 1) % 10, 5, 1'b1);
  endtask

  task automatic do_clr();
    ev_t ev;
    if (m_upper != 0) begin
      m_upper   = 0;
      ev.is_err = 1'b0;
      ev.ovf    = 1'b0;
      ev.val    = m_units;
      sb.push_back(ev);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Clear lands on the same edge as a 9->0 carry: the carry must be lost.
  task automatic hold_clr(input int v);
    ev_t ev;
    m_upper   = 0;
    m_units   = v;
    ev.is_err = 1'b0;
    ev.ovf    = 1'b0;
    ev.val    = v;
    sb.push_back(ev);
    en     = 1'b1;
    cnt_in = 4'(v);
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (4) tick();
  endtask

  task automatic disp_check(input string tag, input int cycles);
    int cnt, k, p10, run;
    bit first;
    logic [NDIG-1:0] prev_an;
    logic [6:0] exp_seg;
    cnt = m_upper * 10 + m_units;
    repeat (2) tick();
    prev_an = an;
    run     = 0;
    first   = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      k = -1;
      for (int i = 0; i < NDIG; i++) if (an[i]) k = i;
      chk({tag, "_onehot"}, 32'($onehot(an)), 32'd1);
      if (k >= 0) begin
        p10 = 1;
        for (int i = 0; i < k; i++) p10 = p10 * 10;
        exp_seg = (BLANK != 0 && k > 0 && cnt < p10) ? 7'h00 : glyph[(cnt / p10) % 10];
        chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
      end
      if (an != prev_an) begin
        chk({tag, "_rot"}, 32'(an), 32'({prev_an[NDIG-2:0], prev_an[NDIG-1]}));
        if (!first) chk({tag, "_dwell"}, run, SCAN_DIV);
        first   = 1'b0;
        run     = 1;
        prev_an = an;
      end else begin
        run++;
      end
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bcd !== prev_bcd) begin
        while (sb.size() > 0 && sb[0].is_err) begin
          total++;
          bad++;
          $display("FAIL err_missing: got no err pulse expected one at count %0d", sb[0].val);
          void'(sb.pop_front());
        end
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bcd_unexpected: got %0h expected no change from %0h", bcd, prev_bcd);
        end else begin
          mon_e = sb.pop_front();
          chk("bcd", 32'(bcd), to_bcd(mon_e.val));
          chk("ovf", 32'(ovf), 32'(mon_e.ovf));
        end
        prev_bcd = bcd;
      end else if (ovf !== 1'b0) begin
        chk("ovf_stray", 32'(ovf), 32'd0);
      end
      if (err !== 1'b0) begin
        if (sb.size() > 0 && sb[0].is_err) begin
          mon_e = sb.pop_front();
          chk("err_hold", 32'(bcd), to_bcd(mon_e.val));
        end else begin
          chk("err_stray", 32'(err), 32'd0);
        end
      end
    end
  end

  initial begin
    int r, v;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    rst = 1'b1; en = 1'b1; clr = 1'b0; cnt_in = 4'd0;
    tick();
    tick();
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_an",  32'(an),  32'd0);
    rst = 1'b0;
    tick();
    chk("first_an",  32'(an),  32'b001);
    chk("first_seg", 32'(seg), 32'h3F);
    prev_bcd = bcd;
    mon_en   = 1'b1;

    model_apply(1, 1'b1);
    cnt_in = 4'd1;
    repeat (3) tick();
    chk("lat_before", 32'(bcd[3:0]), 32'd0);
    tick();
    chk("lat_at", 32'(bcd[3:0]), 32'd1);
    repeat (4) tick();
    for (int i = 2; i <= 10; i++) hold(i % 10, 8, 1'b1);
    chk("t2_end", 32'(bcd), 32'h010);

    goto_cnt(19);
    glitch(8);
    hold(0, 8, 1'b1);
    chk("t3_glitch", 32'(bcd), 32'h020);

    goto_cnt(999);
    hold(0, 8, 1'b1);
    chk("t4_wrap", 32'(bcd), 32'h000);
    goto_cnt(999);
    hold(0, 8, 1'b0);
    chk("t4_noen", 32'(bcd), 32'h990);

    goto_cnt(13);
    hold(12, 10, 1'b1);
    chk("t5_hold", 32'(bcd), 32'h013);
    hold(4, 8, 1'b1);
    chk("t5_resume", 32'(bcd), 32'h014);

    goto_cnt(105);
    disp_check("d105", 3 * NDIG * SCAN_DIV);
    do_clr();
    disp_check("d005", 3 * NDIG * SCAN_DIV);
    goto_cnt(9);
    hold_clr(0);
    chk("clr_carry", 32'(bcd), 32'h000);

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2 && !last_g) begin
        glitch(int'($urandom_range(0, 15)));
        last_g = 1'b1;
      end else if (r == 2 && !last_inv) begin
        hold(int'($urandom_range(10, 15)), int'($urandom_range(5, 8)), 1'b1);
        last_inv = 1'b1;
        last_g   = 1'b0;
      end else if (r == 3 && !last_g) begin
        do_clr();
      end else begin
        v = (r < 6) ? (m_units + 1) % 10 : int'($urandom_range(0, 9));
        hold(v, int'($urandom_range(5, 8)), $urandom_range(0, 3) != 0);
        last_inv = 1'b0;
        last_g   = 1'b0;
      end
    end
    hold(m_units, 6, 1'b1);
    repeat (10) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
